biometric_access_ctrl: RTL and testbench

//  Parametrised successor to the single-cycle biometric check.
//  - Matches a CODE_W biometric sample against NUM_CODES enrollable code slots.
//  - Holds an access grant for GRANT_CYCLES cycles.
//  - Counts consecutive failures and enters a timed lockout after MAX_FAILS misses.
//  - Sits between the biometric sensor front-end and the door/alarm actuators.

---
 rtl/biometric_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_biometric_access_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/biometric_access_ctrl.sv
// rtl/biometric_access_ctrl.sv - biometric code matcher with enrollment table, timed grant and failure lockout
module biometric_access_ctrl #(
    parameter int                CODE_W         = 8,
    parameter int                NUM_CODES      = 4,
    parameter logic [CODE_W-1:0] FACE_CODE      = 8'hAA,
    parameter logic [CODE_W-1:0] VOICE_CODE     = 8'h55,
    parameter int                MAX_FAILS      = 3,
    parameter int                GRANT_CYCLES   = 50,
    parameter int                LOCKOUT_CYCLES = 1000,
    localparam int               IDX_W          = $clog2(NUM_CODES),
    localparam int               FAIL_W         = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bio_valid,
    input  logic [CODE_W-1:0] bio_data,
    output logic              bio_ready,
    input  logic              enroll_we,
    input  logic              enroll_del,
    input  logic [IDX_W-1:0]  enroll_idx,
    input  logic [CODE_W-1:0] enroll_code,
    output logic              access_granted,
    output logic              locked_out,
    output logic [IDX_W-1:0]  match_idx,
    output logic [FAIL_W-1:0] fail_count
);

    localparam int             CNT_MAX     = (GRANT_CYCLES > LOCKOUT_CYCLES) ? GRANT_CYCLES : LOCKOUT_CYCLES;
    localparam int             CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0] NUM_CODES_W = (IDX_W + 1)'(NUM_CODES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [IDX_W-1:0]    match_q, match_d;

    logic [CODE_W-1:0]   slot_code [NUM_CODES];
    logic [NUM_CODES-1:0] slot_valid;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                accept;
    logic                enroll_ok;

    assign bio_ready      = (state_q == IDLE);
    assign access_granted = (state_q == GRANT);
    assign locked_out     = (state_q == LOCKOUT);
    assign match_idx      = match_q;
    assign fail_count     = fail_q;

    assign accept    = bio_valid && bio_ready;
    assign enroll_ok = (state_q != LOCKOUT) && ({1'b0, enroll_idx} < NUM_CODES_W);

    // Priority match: scan high to low so the lowest matching valid slot wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_CODES - 1; i >= 0; i--) begin
            if (slot_valid[i] && (slot_code[i] == bio_data)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Enrollment table; a delete beats a simultaneous write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CODES; i++) begin
                slot_code[i] <= (i == 0) ? FACE_CODE : (i == 1) ? VOICE_CODE : '0;
            end
            slot_valid <= NUM_CODES'(2'b11);
        end else if (enroll_ok) begin
            if (enroll_del) begin
                slot_valid[enroll_idx] <= 1'b0;
            end else if (enroll_we) begin
                slot_code[enroll_idx]  <= enroll_code;
                slot_valid[enroll_idx] <= 1'b1;
            end
        end
    end

    // State, hold counter, failure count and last-grant index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fail_q  <= '0;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            match_q <= match_d;
        end
    end

    // Next-state logic: the counter is loaded with hold-1 so the state lasts exactly hold cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        fail_d  = fail_q;
        match_d = match_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        state_d = GRANT;
                        cnt_d   = CNT_W'(GRANT_CYCLES - 1);
                        fail_d  = '0;
                        match_d = hit_idx;
                    end else if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
                        state_d = LOCKOUT;
                        cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
                        fail_d  = FAIL_W'(MAX_FAILS);
                    end else begin
                        fail_d  = fail_q + FAIL_W'(1);
                    end
                end
            end
            GRANT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_biometric_access_ctrl.sv
// tb/tb_biometric_access_ctrl.sv - directed self-checking bench for biometric_access_ctrl
module tb_biometric_access_ctrl;

    logic       clk;
    logic       rst;
    logic       bio_valid;
    logic [7:0] bio_data;
    logic       bio_ready;
    logic       enroll_we;
    logic       enroll_del;
    logic [1:0] enroll_idx;
    logic [7:0] enroll_code;
    logic       access_granted;
    logic       locked_out;
    logic [1:0] match_idx;
    logic [1:0] fail_count;

    int n_cmp = 0;
    int n_err = 0;

    biometric_access_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .bio_valid      (bio_valid),
        .bio_data       (bio_data),
        .bio_ready      (bio_ready),
        .enroll_we      (enroll_we),
        .enroll_del     (enroll_del),
        .enroll_idx     (enroll_idx),
        .enroll_code    (enroll_code),
        .access_granted (access_granted),
        .locked_out     (locked_out),
        .match_idx      (match_idx),
        .fail_count     (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one sample for one clock; returns at the negedge after the accepting edge
    task automatic send(input logic [7:0] code);
        @(negedge clk);
        bio_valid = 1'b1;
        bio_data  = code;
        @(negedge clk);
        bio_valid = 1'b0;
    endtask

    task automatic enroll(input logic del, input logic [1:0] idx, input logic [7:0] code);
        @(negedge clk);
        enroll_we   = ~del;
        enroll_del  = del;
        enroll_idx  = idx;
        enroll_code = code;
        @(negedge clk);
        enroll_we   = 1'b0;
        enroll_del  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bio_ready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk("wait_idle_timeout", 32'(bio_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst         = 1'b0;
        bio_valid   = 1'b0;
        bio_data    = 8'h00;
        enroll_we   = 1'b0;
        enroll_del  = 1'b0;
        enroll_idx  = 2'd0;
        enroll_code = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(bio_ready),      32'd1);
        chk("rst_granted", 32'(access_granted), 32'd0);
        chk("rst_locked",  32'(locked_out),     32'd0);
        chk("rst_match",   32'(match_idx),      32'd0);
        chk("rst_fail",    32'(fail_count),     32'd0);
        rst = 1'b1;

        // 1: face code grant, 50-cycle hold
        send(8'hAA);
        chk("t1_granted", 32'(access_granted), 32'd1);
        chk("t1_match",   32'(match_idx),      32'd0);
        chk("t1_ready",   32'(bio_ready),      32'd0);
        n = 0;
        while (access_granted && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t1_grant_len", 32'(n), 32'd50);
        chk("t1_ready_after", 32'(bio_ready), 32'd1);

        // 2: two misses then voice grant clears the count
        send(8'h00);
        chk("t2_fail1", 32'(fail_count), 32'd1);
        send(8'h01);
        chk("t2_fail2", 32'(fail_count), 32'd2);
        chk("t2_nogrant", 32'(access_granted), 32'd0);
        send(8'h55);
        chk("t2_granted", 32'(access_granted), 32'd1);
        chk("t2_match",   32'(match_idx),      32'd1);
        chk("t2_fail0",   32'(fail_count),     32'd0);
        wait_idle();

        // 3: three misses -> 1000-cycle lockout, sample during lockout ignored
        send(8'h11);
        send(8'h11);
        chk("t3_fail2", 32'(fail_count), 32'd2);
        send(8'h11);
        chk("t3_locked", 32'(locked_out), 32'd1);
        chk("t3_fail3",  32'(fail_count), 32'd3);
        chk("t3_ready",  32'(bio_ready),  32'd0);
        n = 0;
        while (locked_out && n < 2000) begin
            if (n == 5) begin
                bio_valid = 1'b1;
                bio_data  = 8'hAA;
            end
            if (n == 6) bio_valid = 1'b0;
            n++;
            @(negedge clk);
        end
        bio_valid = 1'b0;
        chk("t3_lock_len",    32'(n),              32'd1000);
        chk("t3_fail_after",  32'(fail_count),     32'd0);
        chk("t3_ready_after", 32'(bio_ready),      32'd1);
        chk("t3_no_grant",    32'(access_granted), 32'd0);

        // 4: enroll slot 2, then delete slot 0
        enroll(1'b0, 2'd2, 8'h3C);
        send(8'h3C);
        chk("t4_granted", 32'(access_granted), 32'd1);
        chk("t4_match",   32'(match_idx),      32'd2);
        wait_idle();
        enroll(1'b1, 2'd0, 8'h00);
        send(8'hAA);
        chk("t4_del_nogrant", 32'(access_granted), 32'd0);
        chk("t4_del_fail",    32'(fail_count),     32'd1);
        chk("t4_match_held",  32'(match_idx),      32'd2);

        // 5: write and sample in same cycle compares against the old table
        @(negedge clk);
        enroll_we   = 1'b1;
        enroll_idx  = 2'd3;
        enroll_code = 8'h77;
        bio_valid   = 1'b1;
        bio_data    = 8'h77;
        @(negedge clk);
        enroll_we   = 1'b0;
        bio_valid   = 1'b0;
        chk("t5_same_nogrant", 32'(access_granted), 32'd0);
        chk("t5_same_fail",    32'(fail_count),     32'd2);
        send(8'h77);
        chk("t5_granted", 32'(access_granted), 32'd1);
        chk("t5_match",   32'(match_idx),      32'd3);
        chk("t5_fail0",   32'(fail_count),     32'd0);

        // 6: reset in the middle of a grant restores the table
        repeat (19) @(negedge clk);
        chk("t6_still_granted", 32'(access_granted), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_granted", 32'(access_granted), 32'd0);
        chk("t6_rst_ready",   32'(bio_ready),      32'd1);
        chk("t6_rst_match",   32'(match_idx),      32'd0);
        chk("t6_rst_fail",    32'(fail_count),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(8'h3C);
        chk("t6_slot2_nogrant", 32'(access_granted), 32'd0);
        chk("t6_slot2_fail",    32'(fail_count),     32'd1);
        send(8'hAA);
        chk("t6_face_granted", 32'(access_granted), 32'd1);
        chk("t6_face_match",   32'(match_idx),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
